// File: rtl/mmio_uart_pkg.sv
// mmio_uart_pkg: serializer states, register offsets and STATUS bit positions shared by mmio_uart_tx
package mmio_uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam int OFF_TXDATA  = 0;
    localparam int OFF_STATUS  = 8;
    localparam int OFF_BAUDDIV = 16;
    localparam int ST_FULL     = 0;
    localparam int ST_EMPTY    = 1;
    localparam int ST_BUSY     = 2;
    localparam int ST_OVF      = 3;
    localparam int ST_PAR      = 4;
    localparam int ST_CNT_LSB  = 8;
    localparam logic [15:0] MIN_DIV = 16'd2;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO; a push into a full FIFO is accepted when a pop happens in the same cycle
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic do_push, do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rptr];

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + AW'(1);
            if (do_pop) rptr <= rptr + AW'(1);
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    // storage needs no reset; only occupied slots are ever read
    always_ff @(posedge clk) begin
        if (do_push) mem[wptr] <= wdata;
    end
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter (TXDATA/STATUS/BAUDDIV); MMIO_UART_TX_PARITY_EN adds even parity
module mmio_uart_tx
    import mmio_uart_pkg::*;
#(
    parameter int N = 64,
    parameter logic [N-1:0] BASE = 64'h8010,
    parameter int FIFO_DEPTH = 8,
    parameter logic [15:0] BAUD_RST = 16'd434
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [N-1:0] addr,
    input  logic         memWrite,
    input  logic         memRead,
    input  logic [N-1:0] writeData,
    output logic [N-1:0] readData,
    output logic         o_hit,
    output logic         o_tx,
    output logic         o_irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef MMIO_UART_TX_PARITY_EN
    localparam state_t AFTER_DATA = PARITY;
    logic par;
`else
    localparam state_t AFTER_DATA = STOP;
`endif

    state_t state, state_n;
    logic [15:0] baud, div_lat, div_n, cnt, cnt_n, eff_div;
    logic [2:0] bit_idx, bit_n;
    logic [7:0] shift, shift_n, head;
    logic [AW:0] count;
    logic [N-1:0] status;
    logic tx_n, pop, full, empty, ovf, done, hit_tx, hit_st, hit_bd, wr_tx, unused_wd;

    assign hit_tx    = addr == BASE + N'(OFF_TXDATA);
    assign hit_st    = addr == BASE + N'(OFF_STATUS);
    assign hit_bd    = addr == BASE + N'(OFF_BAUDDIV);
    assign o_hit     = hit_tx | hit_st | hit_bd;
    assign wr_tx     = memWrite & hit_tx;
    assign eff_div   = baud < MIN_DIV ? MIN_DIV : baud;
    assign done      = cnt == div_lat - 16'd1;
    assign readData  = (memRead & hit_st) ? status : (memRead & hit_bd) ? N'(baud) : '0;
    assign unused_wd = ^writeData[N-1:16];

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(clk), .reset(reset), .push(wr_tx), .pop(pop), .wdata(writeData[7:0]),
        .rdata(head), .full(full), .empty(empty), .count(count)
    );

    // STATUS register image
    always_comb begin
        status = '0;
        status[ST_FULL] = full;
        status[ST_EMPTY] = empty;
        status[ST_BUSY] = state != IDLE;
        status[ST_OVF] = ovf;
        status[ST_CNT_LSB +: 8] = 8'(count);
`ifdef MMIO_UART_TX_PARITY_EN
        status[ST_PAR] = 1'b1;
`endif
    end

    // serializer next state; every bit lasts div_lat clocks
    always_comb begin
        state_n = state;
        cnt_n = cnt + 16'd1;
        bit_n = bit_idx;
        shift_n = shift;
        div_n = div_lat;
        tx_n = 1'b1;
        pop = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!empty) begin
                    pop = 1'b1;
                    shift_n = head;
                    div_n = eff_div;
                    state_n = START;
                end
            end
            START: begin
                tx_n = 1'b0;
                if (done) begin
                    cnt_n = '0;
                    bit_n = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                tx_n = shift[0];
                if (done) begin
                    cnt_n = '0;
                    shift_n = shift >> 1;
                    bit_n = bit_idx + 3'd1;
                    state_n = bit_idx == 3'd7 ? AFTER_DATA : DATA;
                end
            end
`ifdef MMIO_UART_TX_PARITY_EN
            PARITY: begin
                tx_n = par;
                if (done) begin
                    cnt_n = '0;
                    state_n = STOP;
                end
            end
`endif
            STOP: begin
                if (done) begin
                    cnt_n = '0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // state, registered line/irq, BAUDDIV and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt <= '0;
            bit_idx <= '0;
            shift <= '0;
            div_lat <= MIN_DIV;
            baud <= BAUD_RST;
            ovf <= 1'b0;
            o_tx <= 1'b1;
            o_irq <= 1'b1;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            bit_idx <= bit_n;
            shift <= shift_n;
            div_lat <= div_n;
            o_tx <= tx_n;
            o_irq <= empty & (state == IDLE);
            if (memWrite & hit_bd) baud <= writeData[15:0];
            if (wr_tx & full & ~pop) ovf <= 1'b1;
            else if (memWrite & hit_st & writeData[ST_OVF]) ovf <= 1'b0;
        end
    end

`ifdef MMIO_UART_TX_PARITY_EN
    // even parity of the popped byte, held for the parity bit
    always_ff @(posedge clk) begin
        if (reset) par <= 1'b0;
        else if (pop) par <= ^head;
    end
`endif
endmodule
